// File: rtl/flow_pkg.sv
// Shared types and widths for the flow framer.
//   DATA_W  : byte width of the stream
//   ENTRY_W : FIFO entry width, {last, data}
//   in_state_t  : upstream FSM (accepting / discarding an oversize tail)
//   out_state_t : downstream FSM (idle / replaying a frame / inter-frame gap)
package flow_pkg;

  localparam int DATA_W  = 8;
  localparam int ENTRY_W = DATA_W + 1;

  typedef enum logic {
    ACCEPT  = 1'b0,
    DISCARD = 1'b1
  } in_state_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_GAP   = 2'd2
  } out_state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/flow_fifo.sv
// Synchronous FIFO with first-word-fall-through read.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   wr_en/wr_data : push an entry (ignored when full)
//   rd_en/rd_data : rd_data always shows the head; rd_en pops it (ignored when empty)
//   full, empty, count : occupancy status
// Pointers carry one extra MSB so full and empty differ when the indices wrap.
module flow_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             wr_ok;
  logic             rd_ok;

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // The head must be visible in the same cycle the framer decides to pop it,
  // otherwise the one-cycle frame-to-start latency could not be met.
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];
  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/flow_framer.sv
// Store-and-forward framer: buffers whole frames from a valid/ready byte
// stream and replays each one as a gap-free start/in burst, followed by at
// least GAP idle cycles.
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_valid/s_ready   : upstream handshake
//   s_data, s_last    : upstream byte and end-of-frame marker
//   start, in         : downstream burst strobe and byte (registered)
//   busy              : burst or gap in progress
//   err_trunc         : one-cycle pulse when an oversize frame is cut
//   frames            : complete frames currently buffered
module flow_framer
  import flow_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int GAP   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_last,
  output logic                     start,
  output logic [DATA_W-1:0]        in,
  output logic                     busy,
  output logic                     err_trunc,
  output logic [$clog2(DEPTH):0]   frames
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  in_state_t         in_state_reg, in_state_next;
  out_state_t        out_state_reg, out_state_next;
  logic [AW:0]       frames_reg, frames_next;
  logic [AW:0]       fifo_count;
  logic              fifo_full, fifo_empty;
  entry_t            wr_entry, head;
  logic              push, pop, oversize, trunc;
  logic              start_reg, start_next;
  logic [DATA_W-1:0] in_reg, in_next;
  logic [GW-1:0]     gap_cnt_reg, gap_cnt_next;
  logic              err_reg;

  flow_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // No complete frame buffered yet one slot left: the incoming byte fills the
  // FIFO with a single unfinished frame, so it must close that frame.
  assign oversize = (frames_reg == '0) && (fifo_count == (AW+1)'(DEPTH-1));
  assign wr_entry = '{last: s_last || oversize, data: s_data};
  assign trunc    = push && oversize && !s_last;

  // ---------------- input FSM ----------------
  always_comb begin
    in_state_next = in_state_reg;
    case (in_state_reg)
      ACCEPT:  if (trunc) in_state_next = DISCARD;
      DISCARD: if (s_valid && s_last) in_state_next = ACCEPT;
      default: in_state_next = ACCEPT;
    endcase
  end

  always_comb begin
    s_ready = 1'b1;
    push    = 1'b0;
    if (in_state_reg == ACCEPT) begin
      s_ready = !fifo_full;
      push    = s_valid && !fifo_full;
    end
  end

  // ---------------- output FSM ----------------
  always_comb begin
    out_state_next = out_state_reg;
    case (out_state_reg)
      S_IDLE:  if (frames_reg != '0) out_state_next = head.last ? S_GAP : S_BURST;
      S_BURST: if (head.last) out_state_next = S_GAP;
      S_GAP:   if (gap_cnt_reg == GW'(GAP-1)) out_state_next = S_IDLE;
      default: out_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pop          = 1'b0;
    start_next   = 1'b0;
    in_next      = in_reg;
    gap_cnt_next = '0;
    case (out_state_reg)
      S_IDLE: begin
        if (frames_reg != '0) begin
          pop        = !fifo_empty;
          start_next = 1'b1;
          in_next    = head.data;
        end
      end
      // Only complete frames start a burst, so the FIFO cannot run dry here.
      S_BURST: begin
        pop        = !fifo_empty;
        start_next = 1'b1;
        in_next    = head.data;
      end
      S_GAP:   gap_cnt_next = gap_cnt_reg + GW'(1);
      default: ;
    endcase
  end

  // Frame counter: a write and a pop of a last entry on one edge cancel.
  always_comb begin
    frames_next = frames_reg;
    case ({push && wr_entry.last, pop && head.last})
      2'b10:   frames_next = frames_reg + (AW+1)'(1);
      2'b01:   frames_next = frames_reg - (AW+1)'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state_reg  <= ACCEPT;
      out_state_reg <= S_IDLE;
      frames_reg    <= '0;
      start_reg     <= 1'b0;
      in_reg        <= '0;
      gap_cnt_reg   <= '0;
      err_reg       <= 1'b0;
    end else begin
      in_state_reg  <= in_state_next;
      out_state_reg <= out_state_next;
      frames_reg    <= frames_next;
      start_reg     <= start_next;
      in_reg        <= in_next;
      gap_cnt_reg   <= gap_cnt_next;
      err_reg       <= trunc;
    end
  end

  assign start     = start_reg;
  assign in        = in_reg;
  assign busy      = (out_state_reg != S_IDLE);
  assign err_trunc = err_reg;
  assign frames    = frames_reg;

endmodule

// File: tb/tb_flow_framer.sv
`timescale 1ns/1ps
module tb_flow_framer;

  localparam int FW = 5;  // $clog2(16)+1

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // sel routes the shared stimulus/monitor to the GAP=1 (0) or GAP=3 (1) DUT
  logic          sel = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic [7:0]    s_data = 8'h00;

  logic          s_ready1, start1, busy1, err1;
  logic          s_ready3, start3, busy3, err3;
  logic [7:0]    in1, in3;
  logic [FW-1:0] frames1, frames3;

  flow_framer #(.DEPTH(16), .GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid && !sel), .s_ready(s_ready1),
    .s_data(s_data), .s_last(s_last), .start(start1), .in(in1), .busy(busy1),
    .err_trunc(err1), .frames(frames1)
  );

  flow_framer #(.DEPTH(16), .GAP(3)) dut_gap3 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid && sel), .s_ready(s_ready3),
    .s_data(s_data), .s_last(s_last), .start(start3), .in(in3), .busy(busy3),
    .err_trunc(err3), .frames(frames3)
  );

  logic          s_ready_m, start_m, busy_m, err_m;
  logic [7:0]    in_m;
  logic [FW-1:0] frames_m;
  assign s_ready_m = sel ? s_ready3 : s_ready1;
  assign start_m   = sel ? start3   : start1;
  assign busy_m    = sel ? busy3    : busy1;
  assign err_m     = sel ? err3     : err1;
  assign in_m      = sel ? in3      : in1;
  assign frames_m  = sel ? frames3  : frames1;

  int tests = 0;
  int fails = 0;
  int stalls = 0;

  // ---------------- monitor (sole writer of the capture queues) ----------------
  logic [7:0]    bq[$];   // burst bytes
  int            lq[$];   // burst lengths
  int            gq[$];   // start-low run between consecutive bursts
  int            fq[$];   // successive values of frames
  int            err_cnt = 0;
  int            cur_len = 0;
  int            low_run = 0;
  logic          prev_start = 1'b0;
  logic [FW-1:0] prev_frames = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur_len = 0; low_run = 100; prev_start = 1'b0; prev_frames = '0;
    end else begin
      if (start_m) begin
        if (!prev_start && low_run <= 20) gq.push_back(low_run);
        bq.push_back(in_m);
        cur_len++;
      end else if (prev_start) begin
        lq.push_back(cur_len);
        cur_len = 0;
        low_run = 1;
      end else if (low_run < 100) begin
        low_run++;
      end
      if (frames_m != prev_frames) fq.push_back(int'(frames_m));
      prev_frames = frames_m;
      prev_start  = start_m;
      if (err_m) err_cnt++;
    end
  end

  int b0, l0, g0, f0, e0;

  function automatic int qb(input int k);
    return (b0 + k < bq.size()) ? int'(bq[b0 + k]) : -1;
  endfunction
  function automatic int ql(input int k);
    return (l0 + k < lq.size()) ? lq[l0 + k] : -1;
  endfunction
  function automatic int qg(input int k);
    return (g0 + k < gq.size()) ? gq[g0 + k] : -1;
  endfunction
  function automatic int qf(input int k);
    return (f0 + k < fq.size()) ? fq[f0 + k] : -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  // Long idle so the monitor does not treat the next burst as back-to-back.
  task automatic mark();
    repeat (25) @(posedge clk);
    #1;
    b0 = bq.size(); l0 = lq.size(); g0 = gq.size(); f0 = fq.size(); e0 = err_cnt;
    stalls = 0;
  endtask

  // Present one byte; returns at posedge+1 of the accepting edge.
  task automatic send(input logic [7:0] d, input logic l);
    int waited;
    waited = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    forever begin
      @(negedge clk);
      if (s_ready_m) break;
      waited++;
      stalls++;
      if (waited > 200) begin
        check("send_timeout", waited, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_bursts(input int n, input string name);
    int c;
    c = 0;
    while ((lq.size() - l0) < n && c < 400) begin @(posedge clk); c++; end
    c = 0;
    while (busy_m && c < 50) begin @(posedge clk); c++; end
    @(posedge clk);
    #1;
    check({name, "_bursts"}, lq.size() - l0, n);
  endtask

  typedef struct packed {
    logic [19:0][7:0] d;
    int               len;
    int               exp_len;
    int               exp_err;
  } vec_t;

  vec_t vt [6];

  initial begin : stim
    int c;
    logic [7:0] seq_b [6];
    int seq_l [3];

    // ---------- vector table ----------
    for (int i = 0; i < 6; i++) vt[i] = '0;
    vt[0].len = 3;  vt[0].exp_len = 3;  vt[0].exp_err = 0;
    vt[0].d[0] = 8'd3; vt[0].d[1] = 8'd9; vt[0].d[2] = 8'd5;
    vt[1].len = 1;  vt[1].exp_len = 1;  vt[1].exp_err = 0;
    vt[1].d[0] = 8'hA5;
    vt[2].len = 16; vt[2].exp_len = 16; vt[2].exp_err = 0;   // exactly DEPTH
    for (int k = 0; k < 16; k++) vt[2].d[k] = 8'(16 + 3 * k);
    vt[3].len = 20; vt[3].exp_len = 16; vt[3].exp_err = 1;   // oversize
    for (int k = 0; k < 20; k++) vt[3].d[k] = 8'(200 - 5 * k);
    vt[4].len = 2;  vt[4].exp_len = 2;  vt[4].exp_err = 0;   // after truncation
    vt[4].d[0] = 8'h11; vt[4].d[1] = 8'h22;
    vt[5].len = 15; vt[5].exp_len = 15; vt[5].exp_err = 0;
    for (int k = 0; k < 15; k++) vt[5].d[k] = 8'(17 * k);

    // ---------- reset state ----------
    #3;
    check("rst_start", start1, 0);
    check("rst_busy", busy1, 0);
    #9 rst_n = 1'b1;
    @(negedge clk);
    check("rst_s_ready", s_ready1, 1);
    check("rst_in", in1, 0);
    check("rst_err", err1, 0);
    check("rst_frames", frames1, 0);

    // ---------- table-driven frames ----------
    for (int i = 0; i < 6; i++) begin
      mark();
      for (int k = 0; k < vt[i].len; k++) begin
        send(vt[i].d[k], k == vt[i].len - 1);
        if (k == 15 && vt[i].exp_err != 0) check($sformatf("v%0d_err_on_16th", i), err1, 1);
      end
      wait_bursts(1, $sformatf("v%0d", i));
      check($sformatf("v%0d_len", i), ql(0), vt[i].exp_len);
      for (int k = 0; k < vt[i].exp_len; k++)
        check($sformatf("v%0d_byte%0d", i, k), qb(k), int'(vt[i].d[k]));
      check($sformatf("v%0d_err_cnt", i), err_cnt - e0, vt[i].exp_err);
      check($sformatf("v%0d_stalls", i), stalls, 0);
      check($sformatf("v%0d_frames_end", i), frames1, 0);
    end

    // ---------- latency of a 1-byte frame ----------
    mark();
    send(8'h3C, 1'b1);
    check("lat_edgeN_start", start1, 0);
    @(posedge clk); #1;
    check("lat_edgeN1_start", start1, 1);
    check("lat_edgeN1_in", in1, 8'h3C);
    check("lat_edgeN1_busy", busy1, 1);
    @(posedge clk); #1;
    check("lat_edgeN2_start", start1, 0);
    check("lat_edgeN2_busy", busy1, 0);
    check("lat_edgeN2_in_hold", in1, 8'h3C);

    // ---------- back-to-back: {4,5,6} keeps the output busy so {7},{1,2} queue up ----------
    mark();
    seq_b = '{8'd4, 8'd5, 8'd6, 8'd7, 8'd1, 8'd2};
    send(8'd4, 0); send(8'd5, 0); send(8'd6, 1);
    send(8'd7, 1);
    send(8'd1, 0); send(8'd2, 1);
    wait_bursts(3, "b2b");
    seq_l = '{3, 1, 2};
    for (int j = 0; j < 3; j++) check($sformatf("b2b_len%0d", j), ql(j), seq_l[j]);
    for (int j = 0; j < 6; j++) check($sformatf("b2b_byte%0d", j), qb(j), int'(seq_b[j]));
    check("b2b_gap0", qg(0), 1);
    check("b2b_gap1", qg(1), 1);
    check("b2b_frames0", qf(0), 1);
    check("b2b_frames1", qf(1), 2);
    check("b2b_frames2", qf(2), 1);
    check("b2b_frames3", qf(3), 0);
    check("b2b_frames_changes", fq.size() - f0, 4);

    // ---------- fill 16 bytes while a 4-byte burst drains ----------
    mark();
    for (int k = 0; k < 4; k++) send(8'(8'hA0 + k), k == 3);
    for (int k = 0; k < 16; k++) begin
      send(8'(8'hB0 + k), k == 15);
      if (k == 15) begin
        check("fill_ready_when_full", s_ready1, 0);
        @(posedge clk); #1;
        check("fill_ready_after_pop", s_ready1, 1);
      end
    end
    check("fill_stalls", stalls, 0);
    wait_bursts(2, "fill");
    check("fill_len0", ql(0), 4);
    check("fill_len1", ql(1), 16);
    for (int k = 0; k < 4; k++) check($sformatf("fill_a%0d", k), qb(k), 8'hA0 + k);
    for (int k = 0; k < 16; k++) check($sformatf("fill_b%0d", k), qb(4 + k), 8'hB0 + k);
    check("fill_err_cnt", err_cnt - e0, 0);

    // ---------- reset during a burst ----------
    mark();
    for (int k = 0; k < 8; k++) send(8'(8'h60 + k), k == 7);
    c = 0;
    while (!start1 && c < 50) begin @(negedge clk); c++; end
    check("mid_rst_burst_seen", start1, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_start_async", start1, 0);
    check("mid_rst_frames", frames1, 0);
    check("mid_rst_busy", busy1, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_s_ready", s_ready1, 1);
    mark();
    send(8'h5A, 0); send(8'h5B, 1);
    wait_bursts(1, "post_rst");
    check("post_rst_len", ql(0), 2);
    check("post_rst_byte0", qb(0), 8'h5A);
    check("post_rst_byte1", qb(1), 8'h5B);

    // ---------- GAP=3 instance ----------
    sel = 1'b1;
    mark();
    send(8'd1, 0); send(8'd2, 0); send(8'd3, 1);
    send(8'd4, 1);
    send(8'd5, 0); send(8'd6, 1);
    wait_bursts(3, "gap3");
    seq_l = '{3, 1, 2};
    for (int j = 0; j < 3; j++) check($sformatf("gap3_len%0d", j), ql(j), seq_l[j]);
    for (int j = 0; j < 6; j++) check($sformatf("gap3_byte%0d", j), qb(j), j + 1);
    check("gap3_gap0", qg(0), 3);
    check("gap3_gap1", qg(1), 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
